// File: rtl/tri_seq_checker.sv
// Receive-side checker for the 4-bit up/down triangle sequence.
// Locks onto the pattern, tracks direction, flags peaks and troughs, counts sequence errors.
module tri_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int DWELL    = 1,
    parameter int LOCK_LEN = 3,
    parameter int ERRW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             dir,
    output logic             peak,
    output logic             trough,
    output logic             err,
    output logic [ERRW-1:0]  err_count
);

    localparam int                RUNW     = $clog2(LOCK_LEN + 1);
    localparam logic [WIDTH-1:0]  MAX      = '1;
    localparam logic [WIDTH-1:0]  ZERO     = '0;
    localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);
    localparam logic [RUNW-1:0]   RUN_ONE  = RUNW'(1);
    localparam logic [RUNW-1:0]   RUN_LOCK = RUNW'(LOCK_LEN);
    localparam logic [ERRW-1:0]   CNT_MAX  = '1;
    localparam logic [ERRW-1:0]   CNT_ONE  = ERRW'(1);

    typedef enum logic [2:0] {
        ACQ      = 3'd0,
        UP       = 3'd1,
        HOLD_TOP = 3'd2,
        DOWN     = 3'd3,
        HOLD_BOT = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_seeded;
    logic [RUNW-1:0]  r_run;
    logic             r_run_dir;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_exp;
    logic             r_peak;
    logic             r_trough;
    logic             r_err;
    logic [ERRW-1:0]  r_err_count;

    state_t           w_state_n;
    logic             w_seeded_n;
    logic [RUNW-1:0]  w_run_n;
    logic             w_run_dir_n;
    logic [WIDTH-1:0] w_prev_n;
    logic [WIDTH-1:0] w_exp_n;
    logic             w_peak_n;
    logic             w_trough_n;
    logic             w_err_n;
    logic [ERRW-1:0]  w_err_count_n;
    logic             w_acc;
    state_t           w_acc_state;
    logic             w_is_up;
    logic             w_is_dn;

    // Widened compare so 15->0 and 0->15 never count as steps.
    assign w_is_up = ({1'b0, in_data} == ({1'b0, r_prev} + {1'b0, ONE}));
    assign w_is_dn = ({1'b0, r_prev}  == ({1'b0, in_data} + {1'b0, ONE}));

    always_comb begin
        w_state_n     = r_state;
        w_seeded_n    = r_seeded;
        w_run_n       = r_run;
        w_run_dir_n   = r_run_dir;
        w_prev_n      = r_prev;
        w_exp_n       = r_exp;
        w_peak_n      = 1'b0;
        w_trough_n    = 1'b0;
        w_err_n       = 1'b0;
        w_err_count_n = r_err_count;
        w_acc         = 1'b0;
        w_acc_state   = UP;

        if (in_valid) begin
            if (r_state == ACQ) begin
                w_prev_n = in_data;
                if (!r_seeded) begin
                    w_seeded_n = 1'b1;
                    w_run_n    = '0;
                end else if (w_is_up || w_is_dn) begin
                    if ((r_run != '0) && (r_run_dir == w_is_dn)) begin
                        w_run_n = r_run + RUN_ONE;
                    end else begin
                        w_run_n     = RUN_ONE;
                        w_run_dir_n = w_is_dn;
                    end
                    // Lock entry treats this sample as the first accepted one.
                    if (w_run_n == RUN_LOCK) begin
                        w_acc       = 1'b1;
                        w_acc_state = w_is_dn ? DOWN : UP;
                        w_run_n     = '0;
                    end
                end else begin
                    w_run_n = '0;
                end
            end else if (in_data == r_exp) begin
                w_acc       = 1'b1;
                w_acc_state = r_state;
            end else begin
                w_err_n    = 1'b1;
                w_state_n  = ACQ;
                w_prev_n   = in_data;
                w_seeded_n = 1'b1;
                w_run_n    = '0;
                if (r_err_count != CNT_MAX) begin
                    w_err_count_n = r_err_count + CNT_ONE;
                end
            end
        end

        if (w_acc) begin
            case (w_acc_state)
                UP: begin
                    if (in_data == MAX) begin
                        w_peak_n = 1'b1;
                        if (DWELL != 0) begin
                            w_state_n = HOLD_TOP;
                            w_exp_n   = MAX;
                        end else begin
                            w_state_n = DOWN;
                            w_exp_n   = MAX - ONE;
                        end
                    end else begin
                        w_state_n = UP;
                        w_exp_n   = in_data + ONE;
                    end
                end
                HOLD_TOP: begin
                    w_state_n = DOWN;
                    w_exp_n   = MAX - ONE;
                end
                DOWN: begin
                    if (in_data == ZERO) begin
                        w_trough_n = 1'b1;
                        if (DWELL != 0) begin
                            w_state_n = HOLD_BOT;
                            w_exp_n   = ZERO;
                        end else begin
                            w_state_n = UP;
                            w_exp_n   = ONE;
                        end
                    end else begin
                        w_state_n = DOWN;
                        w_exp_n   = in_data - ONE;
                    end
                end
                HOLD_BOT: begin
                    w_state_n = UP;
                    w_exp_n   = ONE;
                end
                default: begin
                    w_state_n = ACQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ACQ;
            r_seeded    <= 1'b0;
            r_run       <= '0;
            r_run_dir   <= 1'b0;
            r_prev      <= '0;
            r_exp       <= '0;
            r_peak      <= 1'b0;
            r_trough    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_n;
            r_seeded    <= w_seeded_n;
            r_run       <= w_run_n;
            r_run_dir   <= w_run_dir_n;
            r_prev      <= w_prev_n;
            r_exp       <= w_exp_n;
            r_peak      <= w_peak_n;
            r_trough    <= w_trough_n;
            r_err       <= w_err_n;
            r_err_count <= w_err_count_n;
        end
    end

    assign locked    = (r_state != ACQ);
    assign dir       = (r_state == ACQ) ? r_run_dir
                                        : ((r_state == DOWN) || (r_state == HOLD_TOP));
    assign peak      = r_peak;
    assign trough    = r_trough;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_tri_seq_checker.sv
// Bench for tri_seq_checker: three instances (default, ERRW=2, DWELL=0) checked each cycle
// against a phase-index model of the triangle period, plus directed scenarios.
module tb_tri_seq_checker;

    localparam int MAXV = 15;
    localparam int LOCK = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic [2:0] o_locked, o_dir, o_peak, o_trough, o_err;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    int P_DWELL [3] = '{1, 1, 0};
    int P_CMAX  [3] = '{255, 3, 255};

    int m_seeded [3];
    int m_prev   [3];
    int m_run    [3];
    int m_rdir   [3];
    int m_locked [3];
    int m_idx    [3];
    int m_pk     [3];
    int m_tr     [3];
    int m_er     [3];
    int m_cnt    [3];

    always #5 clk = ~clk;

    tri_seq_checker #(.WIDTH(4), .DWELL(1), .LOCK_LEN(3), .ERRW(8)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .locked(o_locked[0]), .dir(o_dir[0]), .peak(o_peak[0]), .trough(o_trough[0]),
        .err(o_err[0]), .err_count(cnt0));

    tri_seq_checker #(.WIDTH(4), .DWELL(1), .LOCK_LEN(3), .ERRW(2)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .locked(o_locked[1]), .dir(o_dir[1]), .peak(o_peak[1]), .trough(o_trough[1]),
        .err(o_err[1]), .err_count(cnt1));

    tri_seq_checker #(.WIDTH(4), .DWELL(0), .LOCK_LEN(3), .ERRW(8)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .locked(o_locked[2]), .dir(o_dir[2]), .peak(o_peak[2]), .trough(o_trough[2]),
        .err(o_err[2]), .err_count(cnt2));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One period of the triangle as a function of phase index.
    function automatic int period_len(input int dw);
        return dw ? 2 * (MAXV + 1) : 2 * MAXV;
    endfunction

    function automatic int seqv(input int dw, input int i);
        if (i <= MAXV) return i;
        return dw ? period_len(dw) - 1 - i : period_len(dw) - i;
    endfunction

    function automatic int m_dir(input int k);
        int l;
        l = period_len(P_DWELL[k]);
        if (!m_locked[k]) return m_rdir[k];
        return (m_idx[k] >= MAXV && !(P_DWELL[k] != 0 && m_idx[k] == l - 1)) ? 1 : 0;
    endfunction

    function automatic int dut_cnt(input int k);
        case (k)
            0: return int'(cnt0);
            1: return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_seeded[k] = 0; m_prev[k] = 0; m_run[k] = 0; m_rdir[k] = 0;
            m_locked[k] = 0; m_idx[k] = 0; m_pk[k] = 0; m_tr[k] = 0;
            m_er[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic mark_accept(input int k);
        int l;
        l = period_len(P_DWELL[k]);
        m_pk[k] = (m_idx[k] == MAXV) ? 1 : 0;
        m_tr[k] = (m_idx[k] == (P_DWELL[k] ? l - 1 : 0)) ? 1 : 0;
    endtask

    task automatic model_step(input int k, input bit v, input int s);
        int l, nidx, d, nd;
        l = period_len(P_DWELL[k]);
        nd = 0;
        m_pk[k] = 0; m_tr[k] = 0; m_er[k] = 0;
        if (!v) return;
        if (m_locked[k]) begin
            nidx = (m_idx[k] + 1) % l;
            if (s == seqv(P_DWELL[k], nidx)) begin
                m_idx[k] = nidx;
                mark_accept(k);
            end else begin
                m_er[k] = 1;
                if (m_cnt[k] < P_CMAX[k]) m_cnt[k]++;
                m_locked[k] = 0; m_prev[k] = s; m_seeded[k] = 1; m_run[k] = 0;
            end
        end else if (!m_seeded[k]) begin
            m_seeded[k] = 1; m_prev[k] = s; m_run[k] = 0;
        end else begin
            d = s - m_prev[k];
            if (d == 1 || d == -1) begin
                nd = (d < 0) ? 1 : 0;
                if (m_run[k] > 0 && nd == m_rdir[k]) m_run[k]++;
                else begin m_run[k] = 1; m_rdir[k] = nd; end
            end else begin
                m_run[k] = 0;
            end
            m_prev[k] = s;
            if (m_run[k] == LOCK) begin
                m_locked[k] = 1;
                m_run[k] = 0;
                if (nd == 0) m_idx[k] = s;
                else if (P_DWELL[k]) m_idx[k] = l - 1 - s;
                else m_idx[k] = (s == 0) ? 0 : l - s;
                mark_accept(k);
            end
        end
    endtask

    task automatic compare_all(input string where);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s.i%0d.locked", where, k), o_locked[k], m_locked[k]);
            check($sformatf("%s.i%0d.dir", where, k), o_dir[k], m_dir(k));
            check($sformatf("%s.i%0d.peak", where, k), o_peak[k], m_pk[k]);
            check($sformatf("%s.i%0d.trough", where, k), o_trough[k], m_tr[k]);
            check($sformatf("%s.i%0d.err", where, k), o_err[k], m_er[k]);
            check($sformatf("%s.i%0d.cnt", where, k), dut_cnt(k), m_cnt[k]);
        end
    endtask

    // Called at a negedge; returns at the following negedge after checking.
    task automatic send(input string where, input bit v, input int d);
        in_valid = v;
        in_data  = 4'(d);
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, v, d);
        @(negedge clk);
        compare_all(where);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all("rst");
    endtask

    task automatic send_gappy(input string where, input int d, input bit gaps);
        if (gaps) begin
            for (int g = 0; g < int'($urandom_range(3, 1)); g++) send(where, 1'b0, 0);
        end
        send(where, 1'b1, d);
    endtask

    int peaks, troughs, gpos, gdw, r, v;
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        model_reset();
        @(negedge clk);
        compare_all("init");
        reset = 1'b0;

        // Two clean DWELL=1 periods, then a mismatch and relock; repeated with gaps.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            peaks = 0; troughs = 0;
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < 32; i++) begin
                    send_gappy("period", seqv(1, i), pass[0]);
                    peaks += o_peak[0];
                    troughs += o_trough[0];
                    if (p == 0 && i == 3) check("lock_after_3", o_locked[0], 1);
                end
            end
            check("period.peaks", peaks, 2);
            check("period.troughs", troughs, 2);
            check("period.errcnt", cnt0, 0);
            for (int i = 0; i <= 8; i++) send_gappy("climb", i, pass[0]);
            send_gappy("mis7", 7, pass[0]);
            check("mis7.err", o_err[0], 1);
            check("mis7.cnt", cnt0, 1);
            check("mis7.locked", o_locked[0], 0);
            for (int i = 8; i <= 10; i++) send_gappy("relock", i, pass[0]);
            check("relock.locked", o_locked[0], 1);
        end

        // Saturating error counter on the ERRW=2 instance.
        do_reset();
        for (int e = 0; e < 5; e++) begin
            for (int i = 0; i <= 3; i++) send("sat.lock", 1'b1, i);
            send("sat.mis", 1'b1, 9);
            check("sat.cnt1", cnt1, exp_sat[e]);
        end

        // Async reset while locked with two errors recorded.
        do_reset();
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i <= 5; i++) send("ar.pre", 1'b1, i);
            send("ar.mis", 1'b1, 9);
        end
        for (int i = 0; i <= 6; i++) send("ar.lock", 1'b1, i);
        check("ar.cnt_before", cnt0, 2);
        check("ar.locked_before", o_locked[0], 1);
        reset = 1'b1;
        #1;
        check("ar.locked", o_locked[0], 0);
        check("ar.dir", o_dir[0], 0);
        check("ar.peak", o_peak[0], 0);
        check("ar.trough", o_trough[0], 0);
        check("ar.err", o_err[0], 0);
        check("ar.cnt", cnt0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 7; i <= 9; i++) send("ar.relock", 1'b1, i);
        check("ar.not_yet", o_locked[0], 0);
        send("ar.relock", 1'b1, 10);
        check("ar.relocked", o_locked[0], 1);

        // DWELL=0 instance: single endpoints accepted, doubled peak rejected.
        do_reset();
        for (int i = 10; i <= 15; i++) send("dw0.up", 1'b1, i);
        check("dw0.peak", o_peak[2], 1);
        for (int i = 14; i >= 0; i--) send("dw0.down", 1'b1, i);
        check("dw0.trough", o_trough[2], 1);
        for (int i = 1; i <= 15; i++) send("dw0.up2", 1'b1, i);
        check("dw0.noerr", cnt2, 0);
        send("dw0.dup", 1'b1, 15);
        check("dw0.dup_err", o_err[2], 1);

        // Randomized mostly-on-pattern stream with glitches, jumps and gaps.
        do_reset();
        gpos = 0; gdw = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 600 == 0) begin
                gdw = (n / 600) % 2 == 0 ? 1 : 0;
                gpos = 0;
            end
            if ($urandom % 8 == 0) begin
                send("rnd", 1'b0, int'($urandom % 16));
            end else begin
                r = int'($urandom % 100);
                if (r < 88) begin
                    v = seqv(gdw, gpos);
                    gpos = (gpos + 1) % period_len(gdw);
                end else if (r < 94) begin
                    v = int'($urandom % 16);
                end else begin
                    gpos = int'($urandom % period_len(gdw));
                    v = seqv(gdw, gpos);
                end
                send("rnd", 1'b1, v);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
